// File: rtl/uart_pkg.sv
// Shared UART receive definitions: receiver FSM states and the legal
// range of the bit-period parameter.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_MIN = 4;
    localparam int unsigned CLKS_PER_BIT_MAX = 65535;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_deserializer_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both stages are
// preset to the line's idle level so reset never fakes a start edge.
module rx_sync #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture the raw line, then re-register to settle metastability.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_LEVEL;
            sync_q <= RESET_LEVEL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver. Detects a falling edge on the synchronized line,
// samples every bit at its centre, and emits either a one-cycle data
// strobe or a one-cycle framing-error strobe per frame.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic        IDLE_LEVEL   = 1'b1
) (
    input  logic       aclk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       uart_data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    // Start bit is sampled half a bit after the edge, every later bit one
    // full period after the previous sample.
    localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || CLKS_PER_BIT > CLKS_PER_BIT_MAX) begin : g_bad_clks
        $error("uart_rx_deserializer: CLKS_PER_BIT outside legal range");
    end

    logic             rxs;
    logic             rxs_prev_q;
    rx_state_e        state_q,   state_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;

    rx_sync #(
        .RESET_LEVEL(IDLE_LEVEL)
    ) u_sync (
        .clk_i(aclk),
        .rst_i(reset),
        .d_i  (rx),
        .q_o  (rxs)
    );

    // Next-state logic: edge detect, centre sampling, stop-bit verdict.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (!rxs && rxs_prev_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    // A line already back high mid-start-bit was a glitch.
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Wait out a held-low line so it reports only one error.
                timer_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset abandons any partial frame.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            rxs_prev_q <= IDLE_LEVEL;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            rxs_prev_q <= rxs;
        end
    end

    // Shift register is fully rewritten each frame before use, so no reset.
    always_ff @(posedge aclk) begin
        shift_q <= shift_d;
    end

    assign uart_data       = data_q;
    assign uart_data_valid = valid_q;
    assign frame_err       = ferr_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, aclk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b1, line level when idle (mark).
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, 8N1, LSB first.
REQ-006 SHALL have port uart_data  output  8  last received byte.
REQ-007 SHALL have port uart_data_valid  output  1  one-cycle strobe, uart_data is new.
REQ-008 SHALL have port frame_err  output  1  one-cycle strobe, stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized level rxs.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-012 SHALL define t0 as the first cycle in IDLE where rxs==0 and the previous rxs==1; IDLE->START at t0.
REQ-013 SHALL sample the start bit at t0+floor(CLKS_PER_BIT/2); 0 -> DATA, 1 -> IDLE (glitch rejected, no strobe).
REQ-014 SHALL sample data bit i (i=0..7) at t0+floor(CLKS_PER_BIT/2)+(i+1)*CLKS_PER_BIT, shifting LSB first.
REQ-015 SHALL sample the stop bit at t0+floor(CLKS_PER_BIT/2)+9*CLKS_PER_BIT.
REQ-016 SHALL, on stop bit 1, update uart_data and pulse uart_data_valid for exactly one cycle, the cycle after the stop sample, then go to IDLE.
REQ-017 SHALL, on stop bit 0, pulse frame_err for one cycle, leave uart_data unchanged, no valid, and enter BREAK.
REQ-018 SHALL stay in BREAK until rxs==1, then go to IDLE; a held-low line produces exactly one frame_err.
REQ-019 SHALL accept a new start edge in the cycle immediately after returning to IDLE (back-to-back frames, zero idle bits).
REQ-020 SHALL hold uart_data stable between valid strobes; uart_data_valid and frame_err never assert together.
REQ-021 SHALL use a bit-timer of width $clog2(CLKS_PER_BIT) and a 3-bit bit index; neither wraps during a frame.

Reset
REQ-022 SHALL, while reset is high, force state IDLE, uart_data=8'h00, uart_data_valid=0, frame_err=0, busy=0, synchronizer flops=IDLE_LEVEL.
REQ-023 SHALL, on reset mid-frame, discard the partial byte with no strobe; the first edge after reset deassertion starts a fresh frame.

Structure
REQ-024 SHALL take the state enum and the CLKS_PER_BIT legal-range constants from shared package uart_pkg.
REQ-025 SHALL instantiate one sub-module, rx_sync (2-flop synchronizer, parameterized reset level); all else in this module.
REQ-026 SHALL have an output contract matching the byte/valid input of the simulation UART line printer so it connects without glue.

Verification (CLKS_PER_BIT=8)
REQ-027 SHALL check: frame 0x55 with stop 1 -> single uart_data_valid, uart_data=0x55, exactly 2+4+72+1 cycles after rx falls (sync + start + 9 bits + strobe).
REQ-028 SHALL check: bytes 0x48,0x69,0x0A back-to-back, zero idle -> three valids, data in order, spacing exactly 80 cycles.
REQ-029 SHALL check: 3-cycle low glitch on idle line -> no valid, no frame_err, busy returns low within 7 cycles.
REQ-030 SHALL check: frame 0x41 with stop 0, then line low 40 bit-times -> one frame_err, uart_data keeps prior value; next 0x41 frame received correctly.
REQ-031 SHALL check: reset asserted 1 cycle during bit 3 of 0xA5 -> no strobe, uart_data=0x00, next 0x3C frame yields 0x3C.
